// File: rtl/free_list_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : free_list_ctrl
// Purpose  : Rename-stage controller for a circular physical-register free list.
// Revision : 1.0  initial release
// ============================================================================

module free_list_ctrl #(
  parameter int STACK_SIZE = 64,
  parameter int WIDTH      = 4,
  parameter int INIT_FREE  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alloc_req,
  input  logic [WIDTH-1:0]              alloc_mask,
  output logic                          alloc_grant,
  output logic [WIDTH-1:0]              take_o,
  output logic                          enable_take_o,
  output logic [$clog2(STACK_SIZE)-1:0] ckpt_tag_o,
  input  logic                          commit_valid,
  input  logic [WIDTH-1:0]              commit_mask,
  output logic [WIDTH-1:0]              put_o,
  output logic                          enable_put_o,
  input  logic                          flush_req,
  input  logic [$clog2(STACK_SIZE)-1:0] flush_tag,
  output logic                          rewind_o,
  output logic [$clog2(STACK_SIZE)-1:0] write_tag_o,
  output logic [$clog2(STACK_SIZE)-1:0] free_count,
  output logic                          stall,
  output logic                          err_overflow
);

  localparam int PTR_W = $clog2(STACK_SIZE);

  localparam logic [PTR_W-1:0] GRP       = PTR_W'(WIDTH);
  localparam logic [PTR_W-1:0] INIT_BACK = PTR_W'(INIT_FREE);
  localparam logic [PTR_W:0]   CNT_MAX   = (PTR_W+1)'(STACK_SIZE-1);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_FLUSH   = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] front_q, front_d;
  logic [PTR_W-1:0] back_q,  back_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             err_q,   err_d;

  logic [PTR_W-1:0] commit_pop;
  logic [PTR_W-1:0] pop_eff;
  logic [PTR_W:0]   sum_run;
  logic [PTR_W:0]   sum_chk;
  logic             grant_w;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:     state_d = flush_req ? S_FLUSH : S_RUN;
      S_FLUSH:   state_d = S_RECOVER;
      S_RECOVER: state_d = flush_req ? S_FLUSH : S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  // Grant uses the registered count only; a same-cycle commit is not bypassed.
  assign grant_w = (state_q == S_RUN) && alloc_req && !flush_req && (count_q >= GRP);

  // ---------------------------------------------------------------------------
  // FSM: output logic, all forced low while reset is asserted
  // ---------------------------------------------------------------------------
  always_comb begin
    alloc_grant   = 1'b0;
    take_o        = '0;
    enable_take_o = 1'b0;
    ckpt_tag_o    = '0;
    put_o         = '0;
    enable_put_o  = 1'b0;
    rewind_o      = 1'b0;
    write_tag_o   = '0;
    stall         = 1'b0;
    if (reset) begin
      alloc_grant   = grant_w;
      take_o        = grant_w ? alloc_mask : '0;
      enable_take_o = grant_w;
      ckpt_tag_o    = grant_w ? front_q : '0;
      put_o         = commit_valid ? commit_mask : '0;
      enable_put_o  = commit_valid;
      rewind_o      = flush_req;
      write_tag_o   = flush_req ? flush_tag : '0;
      stall         = alloc_req && !grant_w;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer and count datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    commit_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      commit_pop = commit_pop + {{(PTR_W-1){1'b0}}, commit_mask[i]};
    end
  end

  assign pop_eff = commit_valid ? commit_pop : '0;
  assign sum_chk = {1'b0, count_q} + {1'b0, pop_eff};
  assign sum_run = sum_chk - (grant_w ? {1'b0, GRP} : '0);

  always_comb begin
    back_d  = back_q + pop_eff;
    front_d = front_q;
    count_d = (sum_run > CNT_MAX) ? CNT_MAX[PTR_W-1:0] : sum_run[PTR_W-1:0];
    err_d   = err_q | (commit_valid && (sum_chk > CNT_MAX));
    if (flush_req) begin
      // Entries between the restored front and the (post-commit) back are free again.
      front_d = flush_tag;
      count_d = back_d - flush_tag;
    end else if (grant_w) begin
      front_d = front_q + GRP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      front_q <= '0;
      back_q  <= INIT_BACK;
      count_q <= INIT_BACK;
      err_q   <= 1'b0;
    end else begin
      front_q <= front_d;
      back_q  <= back_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign free_count   = count_q;
  assign err_overflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_free_list_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list_ctrl
// Purpose  : Directed plus randomized self-checking bench for free_list_ctrl.
// Revision : 1.0  initial release
// ============================================================================

module tb_free_list_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       alloc_req;
  logic [3:0] alloc_mask;
  logic       alloc_grant;
  logic [3:0] take_o;
  logic       enable_take_o;
  logic [5:0] ckpt_tag_o;
  logic       commit_valid;
  logic [3:0] commit_mask;
  logic [3:0] put_o;
  logic       enable_put_o;
  logic       flush_req;
  logic [5:0] flush_tag;
  logic       rewind_o;
  logic [5:0] write_tag_o;
  logic [5:0] free_count;
  logic       stall;
  logic       err_overflow;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: pointers and count as plain integers mod 64.
  int m_front, m_back, m_cnt, m_blk;   // m_blk = cycles left with grants blocked
  bit m_err;
  int last_tag = 0;

  always #5 clk = ~clk;

  free_list_ctrl dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_mask(alloc_mask), .alloc_grant(alloc_grant),
    .take_o(take_o), .enable_take_o(enable_take_o), .ckpt_tag_o(ckpt_tag_o),
    .commit_valid(commit_valid), .commit_mask(commit_mask),
    .put_o(put_o), .enable_put_o(enable_put_o),
    .flush_req(flush_req), .flush_tag(flush_tag),
    .rewind_o(rewind_o), .write_tag_o(write_tag_o),
    .free_count(free_count), .stall(stall), .err_overflow(err_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_grant();
    return reset && (m_blk == 0) && alloc_req && !flush_req && (m_cnt >= 4);
  endfunction

  function automatic int pop_in();
    return commit_valid ? $countones(commit_mask) : 0;
  endfunction

  task automatic model_step();
    int pop, nb, sum;
    bit g;
    if (!reset) begin
      m_front = 0; m_back = 32; m_cnt = 32; m_err = 1'b0; m_blk = 0;
    end else begin
      g   = exp_grant();
      pop = pop_in();
      if (commit_valid && (m_cnt + pop > 63)) m_err = 1'b1;
      nb = (m_back + pop) % 64;
      if (flush_req) begin
        m_front = flush_tag;
        m_cnt   = (nb - int'(flush_tag) + 64) % 64;
      end else begin
        if (g) begin
          last_tag = m_front;
          m_front  = (m_front + 4) % 64;
        end
        sum   = m_cnt - (g ? 4 : 0) + pop;
        m_cnt = (sum > 63) ? 63 : sum;
      end
      m_back = nb;
      // A flush blocks grants for its own cycle plus two more; a flush seen
      // in the first blocked cycle does not extend the window.
      if (m_blk == 2)     m_blk = 1;
      else if (flush_req) m_blk = 2;
      else if (m_blk == 1) m_blk = 0;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit g;
      g = exp_grant();
      chk("alloc_grant", alloc_grant, g);
      chk("enable_take", enable_take_o, g);
      chk("take_o", take_o, g ? alloc_mask : 4'd0);
      chk("ckpt_tag", ckpt_tag_o, g ? m_front : 0);
      chk("put_o", put_o, (reset && commit_valid) ? commit_mask : 4'd0);
      chk("enable_put", enable_put_o, reset && commit_valid);
      chk("rewind_o", rewind_o, reset && flush_req);
      chk("write_tag", write_tag_o, (reset && flush_req) ? flush_tag : 6'd0);
      chk("stall", stall, reset && alloc_req && !g);
      chk("free_count", free_count, m_cnt);
      chk("err_overflow", err_overflow, m_err);
    end
  end

  task automatic drive(input bit ar, input logic [3:0] am, input bit cv,
                       input logic [3:0] cm, input bit fr, input logic [5:0] ft);
    alloc_req = ar; alloc_mask = am; commit_valid = cv; commit_mask = cm;
    flush_req = fr; flush_tag = ft;
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    reset = 1'b0;
    alloc_req = 1'b0; alloc_mask = '0; commit_valid = 1'b0; commit_mask = '0;
    flush_req = 1'b0; flush_tag = '0;
    nxt();
    chk_en = 1'b1;

    // Reset state; combinational outputs suppressed even with requests active.
    drive(1, 4'hF, 1, 4'hF, 1, 6'd9);
    chk("rst_count", free_count, 32);
    chk("rst_err", err_overflow, 0);
    chk("rst_grant", alloc_grant, 0);
    chk("rst_rewind", rewind_o, 0);
    nxt();
    reset = 1'b1;

    // Eight grants drain 32 entries; ninth request stalls.
    for (int i = 0; i < 9; i++) begin
      drive(1, 4'hF, 0, 4'h0, 0, 6'd0);
      chk("drain_grant", alloc_grant, (i < 8));
      chk("drain_tag", ckpt_tag_o, (i < 8) ? 4 * i : 0);
      chk("drain_stall", stall, (i == 8));
      nxt();
    end
    chk("drain_count", free_count, 0);

    // Commit-only refill with no same-cycle bypass.
    drive(1, 4'hF, 1, 4'b1011, 0, 6'd0);
    chk("refill_stall0", stall, 1);
    nxt();
    drive(1, 4'hF, 1, 4'b0001, 0, 6'd0);
    chk("refill_cnt3", free_count, 3);
    chk("refill_stall1", stall, 1);
    nxt();
    drive(1, 4'h5, 0, 4'h0, 0, 6'd0);
    chk("refill_cnt4", free_count, 4);
    chk("refill_grant", alloc_grant, 1);
    chk("refill_tag", ckpt_tag_o, 32);
    chk("refill_take", take_o, 4'h5);
    nxt();

    // Grant and commit together at count 8.
    repeat (2) begin drive(0, 4'h0, 1, 4'hF, 0, 6'd0); nxt(); end
    drive(1, 4'hF, 1, 4'hF, 0, 6'd0);
    chk("gc_count", free_count, 8);
    chk("gc_tag", ckpt_tag_o, 36);
    nxt();
    drive(0, 4'h0, 0, 4'h0, 0, 6'd0);
    chk("gc_count_after", free_count, 8);
    nxt();

    // Flush with a same-cycle request; back = 48, tag 8 gives 40 free.
    drive(1, 4'hF, 0, 4'h0, 1, 6'd8);
    chk("fl_rewind", rewind_o, 1);
    chk("fl_wtag", write_tag_o, 8);
    chk("fl_grant", alloc_grant, 0);
    nxt();
    for (int i = 0; i < 2; i++) begin
      drive(1, 4'hF, 0, 4'h0, 0, 6'd0);
      chk("fl_blocked", alloc_grant, 0);
      chk("fl_count", free_count, 40);
      nxt();
    end
    drive(1, 4'hF, 0, 4'h0, 0, 6'd0);
    chk("fl_resume", alloc_grant, 1);
    chk("fl_resume_tag", ckpt_tag_o, 8);
    nxt();

    // Front-pointer wrap: restore to 60, then two grants tag 60 then 0.
    drive(0, 4'h0, 0, 4'h0, 1, 6'd60);
    nxt();
    drive(0, 4'h0, 0, 4'h0, 0, 6'd0);
    chk("wrap_count", free_count, 52);
    nxt();
    drive(0, 4'h0, 0, 4'h0, 0, 6'd0);
    nxt();
    drive(1, 4'hF, 0, 4'h0, 0, 6'd0);
    chk("wrap_tag60", ckpt_tag_o, 60);
    nxt();
    drive(1, 4'hF, 0, 4'h0, 0, 6'd0);
    chk("wrap_tag0", ckpt_tag_o, 0);
    nxt();

    // Overflow: climb from 44 to 62, then a 4-entry commit saturates.
    repeat (4) begin drive(0, 4'h0, 1, 4'hF, 0, 6'd0); nxt(); end
    drive(0, 4'h0, 1, 4'b0011, 0, 6'd0);
    nxt();
    drive(0, 4'h0, 1, 4'hF, 0, 6'd0);
    chk("ovf_pre_count", free_count, 62);
    chk("ovf_pre_err", err_overflow, 0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'h0, 0, 4'h0, 0, 6'd0);
      chk("ovf_err", err_overflow, 1);
      chk("ovf_count", free_count, 63);
      nxt();
    end
    reset = 1'b0;
    nxt();
    drive(1, 4'hF, 0, 4'h0, 0, 6'd0);
    chk("ovf_clear_err", err_overflow, 0);
    chk("ovf_clear_count", free_count, 32);
    nxt();
    reset = 1'b1;

    // Randomized traffic: commit-heavy first half, allocation-heavy second.
    for (int i = 0; i < 3000; i++) begin
      bit ar, cv, fr;
      logic [5:0] ft;
      ar = ($urandom_range(99) < ((i < 1500) ? 30 : 70));
      cv = ($urandom_range(99) < ((i < 1500) ? 70 : 35));
      fr = ($urandom_range(99) < 5);
      ft = ($urandom_range(1) == 1) ? 6'(last_tag) : 6'($urandom_range(63));
      reset = ($urandom_range(499) != 0);
      drive(ar, 4'($urandom_range(15)), cv, 4'($urandom_range(15)), fr, ft);
      nxt();
    end
    reset = 1'b1;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
